// File: rtl/pu_conn_context_engine.sv
// Multi-channel connection-context engine: per-channel RCI->SCI indirection and context word read/write.
// Optional CONN_CTX_PARITY_EN: even parity per context word plus a saturating mismatch counter.
module pu_conn_context_engine #(
  parameter int NUM_CH = 20,
  parameter int DATA_W = 64,
  parameter int RCI_W  = 10,
  parameter int SCI_W  = 8,
  parameter int WORD_W = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             tbl_wr,
  input  logic [RCI_W-1:0]                 tbl_waddr,
  input  logic [SCI_W-1:0]                 tbl_wdata,
  input  logic                             tbl_wvalid,
  input  logic [NUM_CH-1:0]                ch_req,
  output logic [NUM_CH-1:0]                ch_rdy,
  input  logic [NUM_CH-1:0]                ch_wr,
  input  logic [NUM_CH-1:0][RCI_W-1:0]     ch_rci,
  input  logic [NUM_CH-1:0][WORD_W-1:0]    ch_word,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]                ch_ack,
  output logic [NUM_CH-1:0]                ch_err,
  output logic [NUM_CH-1:0][DATA_W-1:0]    ch_rdata
`ifdef CONN_CTX_PARITY_EN
  ,
  output logic [15:0]                      ctx_par_err_cnt
`endif
);

`ifdef CONN_CTX_PARITY_EN
  localparam int CTX_W = DATA_W + 1;

  function automatic logic par_even(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  localparam int CTX_W = DATA_W;
`endif
  localparam int CTX_AW = SCI_W + WORD_W;

  logic [NUM_CH-1:0]              hold_wr_r, pend_r, rdy_r;
  logic [NUM_CH-1:0][RCI_W-1:0]   hold_rci_r;
  logic [NUM_CH-1:0][WORD_W-1:0]  hold_word_r;
  logic [NUM_CH-1:0][DATA_W-1:0]  hold_wdata_r;
  logic [CH_W-1:0]                ptr_r, gnt_id_s, s1_id_r, s2_id_r;
  logic                           gnt_vld_s, s1_vld_r, s1_wr_r, s2_vld_r, s2_wr_r, s2_tvld_r;
  logic [WORD_W-1:0]              s1_word_r;
  logic [DATA_W-1:0]              s1_wdata_r;
  logic                           tbl_wr_r;
  logic [RCI_W-1:0]               tbl_waddr_r;
  logic [SCI_W:0]                 tbl_wentry_r, tbl_q_r;
  logic [SCI_W:0]                 tbl_mem_r [2**RCI_W];
  logic [CTX_W-1:0]               ctx_mem_r [2**CTX_AW];
  logic [CTX_W-1:0]               ctx_q_r, ctx_wdata_s;
  logic [CTX_AW-1:0]              ctx_addr_s;
  logic                           ctx_we_s, par_bad_s;
  logic [NUM_CH-1:0]              ack_r, err_r;
  logic [NUM_CH-1:0][DATA_W-1:0]  rdata_r;

  // Round-robin pick among pending channels, starting at ptr_r and wrapping.
  always_comb begin
    int idx;
    gnt_vld_s = 1'b0;
    gnt_id_s  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx       = (int'(ptr_r) + i >= NUM_CH) ? int'(ptr_r) + i - NUM_CH : int'(ptr_r) + i;
      gnt_id_s  = (!gnt_vld_s && pend_r[idx]) ? CH_W'(idx) : gnt_id_s;
      gnt_vld_s = gnt_vld_s | pend_r[idx];
    end
  end

  // Channel holding registers, pending flags and ready handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_r       <= '0;
      rdy_r        <= '1;
      hold_wr_r    <= '0;
      hold_rci_r   <= '0;
      hold_word_r  <= '0;
      hold_wdata_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_req[c] && rdy_r[c]) begin
          hold_wr_r[c]    <= ch_wr[c];
          hold_rci_r[c]   <= ch_rci[c];
          hold_word_r[c]  <= ch_word[c];
          hold_wdata_r[c] <= ch_wdata[c];
          pend_r[c]       <= 1'b1;
          rdy_r[c]        <= 1'b0;
        end
      end
      if (gnt_vld_s) pend_r[gnt_id_s] <= 1'b0;
      // Ready comes back on the same edge that registers the ack.
      if (s2_vld_r) rdy_r[s2_id_r] <= 1'b1;
    end
  end

  // Grant stage: advance the arbiter pointer and load S1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r      <= '0;
      s1_vld_r   <= 1'b0;
      s1_id_r    <= '0;
      s1_wr_r    <= 1'b0;
      s1_word_r  <= '0;
      s1_wdata_r <= '0;
    end else begin
      s1_vld_r <= gnt_vld_s;
      if (gnt_vld_s) begin
        ptr_r      <= (gnt_id_s == CH_W'(NUM_CH - 1)) ? '0 : gnt_id_s + 1'b1;
        s1_id_r    <= gnt_id_s;
        s1_wr_r    <= hold_wr_r[gnt_id_s];
        s1_word_r  <= hold_word_r[gnt_id_s];
        s1_wdata_r <= hold_wdata_r[gnt_id_s];
      end
    end
  end

  // Table programming is registered one cycle ahead of the RAM write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tbl_wr_r     <= 1'b0;
      tbl_waddr_r  <= '0;
      tbl_wentry_r <= '0;
    end else begin
      tbl_wr_r     <= tbl_wr;
      tbl_waddr_r  <= tbl_waddr;
      tbl_wentry_r <= {tbl_wvalid, tbl_wdata};
    end
  end

  // Indirection RAM: read-old on a same-cycle write; valid bits deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_r) tbl_mem_r[tbl_waddr_r] <= tbl_wentry_r;
    tbl_q_r <= tbl_mem_r[hold_rci_r[gnt_id_s]];
  end

  assign ctx_addr_s = {tbl_q_r[SCI_W-1:0], s1_word_r};
  assign ctx_we_s   = s1_vld_r & s1_wr_r & tbl_q_r[SCI_W];
`ifdef CONN_CTX_PARITY_EN
  assign ctx_wdata_s = {par_even(s1_wdata_r), s1_wdata_r};
`else
  assign ctx_wdata_s = s1_wdata_r;
`endif

  // Context RAM: contents survive reset; writes are gated by the table valid bit.
  always_ff @(posedge clk) begin
    if (ctx_we_s) ctx_mem_r[ctx_addr_s] <= ctx_wdata_s;
    ctx_q_r <= ctx_mem_r[ctx_addr_s];
  end

  // S2 control pipeline alongside the context RAM access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld_r  <= 1'b0;
      s2_id_r   <= '0;
      s2_wr_r   <= 1'b0;
      s2_tvld_r <= 1'b0;
    end else begin
      s2_vld_r  <= s1_vld_r;
      s2_id_r   <= s1_id_r;
      s2_wr_r   <= s1_wr_r;
      s2_tvld_r <= tbl_q_r[SCI_W];
    end
  end

`ifdef CONN_CTX_PARITY_EN
  assign par_bad_s = s2_vld_r & ~s2_wr_r & s2_tvld_r & (^ctx_q_r);
`else
  assign par_bad_s = 1'b0;
`endif

  // Registered completion outputs: one-cycle ack, error and read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_r   <= '0;
      err_r   <= '0;
      rdata_r <= '0;
    end else begin
      ack_r   <= '0;
      err_r   <= '0;
      rdata_r <= '0;
      if (s2_vld_r) begin
        ack_r[s2_id_r]   <= 1'b1;
        err_r[s2_id_r]   <= ~s2_tvld_r | par_bad_s;
        rdata_r[s2_id_r] <= (!s2_wr_r && s2_tvld_r) ? ctx_q_r[DATA_W-1:0] : '0;
      end
    end
  end

`ifdef CONN_CTX_PARITY_EN
  logic [15:0] par_cnt_r;

  // Saturating count of context reads with a parity mismatch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) par_cnt_r <= 16'd0;
    else if (par_bad_s && par_cnt_r != 16'hFFFF) par_cnt_r <= par_cnt_r + 16'd1;
    else par_cnt_r <= par_cnt_r;
  end

  assign ctx_par_err_cnt = par_cnt_r;
`endif

  assign ch_rdy   = rdy_r;
  assign ch_ack   = ack_r;
  assign ch_err   = err_r;
  assign ch_rdata = rdata_r;

endmodule

// File: tb/tb_pu_conn_context_engine.sv
// Directed, table-driven bench for pu_conn_context_engine (default build; parity case when CONN_CTX_PARITY_EN is set).
module tb_pu_conn_context_engine;
  localparam int NUM_CH = 20, DATA_W = 64, RCI_W = 10, SCI_W = 8, WORD_W = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic tbl_wr = 1'b0, tbl_wvalid = 1'b0;
  logic [RCI_W-1:0] tbl_waddr = '0;
  logic [SCI_W-1:0] tbl_wdata = '0;
  logic [NUM_CH-1:0] ch_req = '0, ch_wr = '0, ch_rdy, ch_ack, ch_err;
  logic [NUM_CH-1:0][RCI_W-1:0]  ch_rci   = '0;
  logic [NUM_CH-1:0][WORD_W-1:0] ch_word  = '0;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata = '0;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_rdata;
`ifdef CONN_CTX_PARITY_EN
  logic [15:0] ctx_par_err_cnt;
`endif

  int checks = 0, errors = 0;

  pu_conn_context_engine #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RCI_W(RCI_W), .SCI_W(SCI_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rstn(rstn),
    .tbl_wr(tbl_wr), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .tbl_wvalid(tbl_wvalid),
    .ch_req(ch_req), .ch_rdy(ch_rdy), .ch_wr(ch_wr), .ch_rci(ch_rci), .ch_word(ch_word),
    .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err), .ch_rdata(ch_rdata)
`ifdef CONN_CTX_PARITY_EN
    , .ctx_par_err_cnt(ctx_par_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          ch;
    logic        wr;
    int          rci;
    int          word;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int c);
    logic [63:0] v;
    v = 64'd0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] pre_data(input int c);
    return 64'hC0DE_0000_0000_0000 + 64'(c) * 64'h0101;
  endfunction

  task automatic tbl_prog(input int rci, input int sci, input logic v);
    @(negedge clk);
    tbl_wr = 1'b1; tbl_waddr = RCI_W'(rci); tbl_wdata = SCI_W'(sci); tbl_wvalid = v;
    @(negedge clk);
    tbl_wr = 1'b0;
  endtask

  task automatic drive_req(input int c, input logic wr, input int rci, input int word, input logic [63:0] d);
    ch_req[c] = 1'b1; ch_wr[c] = wr; ch_rci[c] = RCI_W'(rci);
    ch_word[c] = WORD_W'(word); ch_wdata[c] = d;
  endtask

  // Single access: expects ack exactly four cycles after the request edge.
  task automatic access(input int c, input logic wr, input int rci, input int word, input logic [63:0] d,
                        input logic eerr, input logic [63:0] erd, input string tag);
    int k;
    @(negedge clk);
    drive_req(c, wr, rci, word, d);
    @(negedge clk);
    ch_req = '0;
    k = 1;
    while (!ch_ack[c] && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd4);
    chk({tag, "_ack"}, 64'(ch_ack), onehot(c));
    chk({tag, "_err"}, 64'(ch_err[c]), 64'(eerr));
    chk({tag, "_rdata"}, ch_rdata[c], erd);
    chk({tag, "_rdy"}, 64'(ch_rdy[c]), 64'd1);
  endtask

  initial begin
    int n;
    vecs[0] = '{3,  1'b1, 8, 2,  64'hAAAA,                 1'b0, 64'h0};
    vecs[1] = '{4,  1'b1, 7, 2,  64'h1234,                 1'b1, 64'h0};
    vecs[2] = '{4,  1'b0, 7, 2,  64'h0,                    1'b1, 64'h0};
    vecs[3] = '{5,  1'b0, 8, 2,  64'h0,                    1'b0, 64'hAAAA};
    vecs[4] = '{6,  1'b1, 5, 15, 64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 64'h0};
    vecs[5] = '{7,  1'b0, 5, 15, 64'h0,                    1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{8,  1'b0, 5, 1,  64'h0,                    1'b0, 64'hDEAD_BEEF};
    vecs[7] = '{19, 1'b1, 8, 0,  64'h0123_4567_89AB_CDEF,  1'b0, 64'h0};
    vecs[8] = '{0,  1'b0, 8, 0,  64'h0,                    1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[9] = '{12, 1'b0, 6, 1,  64'h0,                    1'b0, 64'hDEAD_BEEF};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rdy", 64'(ch_rdy), 64'hF_FFFF);
    chk("reset_ack", 64'(ch_ack), 64'd0);
    chk("reset_err", 64'(ch_err), 64'd0);
    chk("reset_rdata2", ch_rdata[2], 64'd0);
    rstn = 1'b1;

    tbl_prog(5, 3, 1'b1);
    tbl_prog(6, 3, 1'b1);
    tbl_prog(7, 20, 1'b1);
    tbl_prog(7, 20, 1'b0);
    tbl_prog(8, 20, 1'b1);
    repeat (2) @(negedge clk);

    access(2, 1'b1, 5, 1, 64'hDEAD_BEEF, 1'b0, 64'h0, "ch2_write");

    // Hand-checked latency and ready window for a read
    @(negedge clk);
    drive_req(2, 1'b0, 5, 1, 64'h0);
    @(negedge clk);
    ch_req = '0;
    for (int k = 1; k <= 3; k++) begin
      chk("lat_rdy_low", 64'(ch_rdy[2]), 64'd0);
      chk("lat_no_ack", 64'(ch_ack), 64'd0);
      @(negedge clk);
    end
    chk("lat_ack", 64'(ch_ack), onehot(2));
    chk("lat_rdata", ch_rdata[2], 64'hDEAD_BEEF);
    chk("lat_err", 64'(ch_err[2]), 64'd0);
    chk("lat_rdy_back", 64'(ch_rdy[2]), 64'd1);
    @(negedge clk);
    chk("lat_ack_pulse", 64'(ch_ack), 64'd0);
    chk("lat_rdata_clear", ch_rdata[2], 64'd0);

    for (int i = 0; i < 10; i++)
      access(vecs[i].ch, vecs[i].wr, vecs[i].rci, vecs[i].word, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Request while busy is ignored
    @(negedge clk);
    drive_req(1, 1'b0, 5, 1, 64'h0);
    @(negedge clk);
    drive_req(1, 1'b1, 5, 1, 64'hBAD0_BAD0);
    @(negedge clk);
    ch_req = '0;
    n = 0;
    repeat (12) begin
      if (ch_ack[1]) begin
        n++;
        chk("busy_rdata", ch_rdata[1], 64'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    chk("busy_ack_count", 64'(n), 64'd1);
    access(1, 1'b0, 5, 1, 64'h0, 1'b0, 64'hDEAD_BEEF, "busy_after");

    // Table write racing a table read returns the old mapping
    tbl_prog(9, 4, 1'b1);
    tbl_prog(11, 10, 1'b1);
    repeat (2) @(negedge clk);
    access(0, 1'b1, 9, 3, 64'h4444, 1'b0, 64'h0, "haz_pre4");
    access(0, 1'b1, 11, 3, 64'hAAAA_0010, 1'b0, 64'h0, "haz_pre10");
    @(negedge clk);
    drive_req(0, 1'b0, 9, 3, 64'h0);
    @(negedge clk);
    ch_req = '0;
    tbl_wr = 1'b1; tbl_waddr = 10'd9; tbl_wdata = 8'd10; tbl_wvalid = 1'b1;
    @(negedge clk);
    tbl_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("haz_ack", 64'(ch_ack), onehot(0));
    chk("haz_old_data", ch_rdata[0], 64'h4444);
    repeat (2) @(negedge clk);
    access(0, 1'b0, 9, 3, 64'h0, 1'b0, 64'hAAAA_0010, "haz_new_map");

    // All channels at once: consecutive acks in channel order
    for (int c = 0; c < NUM_CH; c++) tbl_prog(100 + c, 30 + c, 1'b1);
    repeat (2) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) access(c, 1'b1, 100 + c, 0, pre_data(c), 1'b0, 64'h0, "preload");
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) drive_req(c, 1'b0, 100 + c, 0, 64'h0);
    @(negedge clk);
    ch_req = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      @(negedge clk);
      chk($sformatf("all_ack%0d", k), 64'(ch_ack), onehot(k));
      chk($sformatf("all_rdata%0d", k), ch_rdata[k], pre_data(k));
    end
    @(negedge clk);
    chk("all_done", 64'(ch_ack), 64'd0);

    // Pointer wrap: ch0 ahead of ch19
    drive_req(19, 1'b0, 119, 0, 64'h0);
    drive_req(0, 1'b0, 100, 0, 64'h0);
    @(negedge clk);
    ch_req = '0;
    repeat (3) @(negedge clk);
    chk("wrap_first", 64'(ch_ack), onehot(0));
    @(negedge clk);
    chk("wrap_second", 64'(ch_ack), onehot(19));
    chk("wrap_rdata19", ch_rdata[19], pre_data(19));

    // Reset with three accesses in flight
    @(negedge clk);
    drive_req(5, 1'b0, 105, 0, 64'h0);
    drive_req(6, 1'b0, 106, 0, 64'h0);
    drive_req(7, 1'b0, 107, 0, 64'h0);
    @(negedge clk);
    ch_req = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_rdy", 64'(ch_rdy), 64'hF_FFFF);
    chk("mid_rst_ack", 64'(ch_ack), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    repeat (8) begin
      if (ch_ack != '0) n++;
      @(negedge clk);
    end
    chk("mid_rst_no_acks", 64'(n), 64'd0);
    chk("mid_rst_rdy_after", 64'(ch_rdy), 64'hF_FFFF);
    drive_req(7, 1'b0, 107, 0, 64'h0);
    drive_req(0, 1'b0, 100, 0, 64'h0);
    @(negedge clk);
    ch_req = '0;
    repeat (3) @(negedge clk);
    chk("ptr_reset_first", 64'(ch_ack), onehot(0));
    @(negedge clk);
    chk("ptr_reset_second", 64'(ch_ack), onehot(7));
    access(3, 1'b0, 6, 1, 64'h0, 1'b0, 64'hDEAD_BEEF, "ctx_retained");

`ifdef CONN_CTX_PARITY_EN
    access(2, 1'b1, 5, 4, 64'h0F, 1'b0, 64'h0, "par_write");
    chk("par_cnt_zero", 64'(ctx_par_err_cnt), 64'd0);
    dut.ctx_mem_r[{8'd3, 4'd4}][DATA_W] = ~dut.ctx_mem_r[{8'd3, 4'd4}][DATA_W];
    access(2, 1'b0, 5, 4, 64'h0, 1'b1, 64'h0F, "par_read");
    chk("par_cnt_one", 64'(ctx_par_err_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
